// File: rtl/bep_frame_encode.sv
// Host-loaded 12-byte register file serialised as a 96-bit LSB-first frame on serial_data/serial_clock.
// Latency: first LOW one cycle after start, busy for 192*CLK_DIV+GAP_CYCLES cycles; start while busy is dropped.
module bep_frame_encode #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] address,
  input  logic [7:0] parallel_in,
  input  logic       write_enable,
  output logic [7:0] parallel_out,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       serial_data,
  output logic       serial_clock
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

  localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  logic [7:0]    regs [12];
  logic [95:0]   snap;
  logic [95:0]   shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    bit_q, bit_d;
  state_t        state_q, state_d;
  logic          busy_d, done_d, sclk_d, sdata_d;

  always_comb begin
    snap = '0;
    for (int i = 0; i < 12; i++) snap[i*8 +: 8] = regs[i];
  end

  assign parallel_out = (address < 4'd12) ? regs[address] : 8'h00;

  // Register file stays writable mid-frame; the shift buffer holds the frame's own copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 12; i++) regs[i] <= 8'h00;
    end else if (write_enable && address < 4'd12) begin
      regs[address] <= parallel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      busy         <= busy_d;
      done         <= done_d;
      serial_clock <= sclk_d;
      serial_data  <= sdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOW;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = snap;
        end
      end
      LOW: begin
        if (cnt_q == DIV_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == 7'd95) begin
            state_d = GAP;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they describe.
  always_comb begin
    busy_d  = (state_d != IDLE);
    sclk_d  = (state_d == HIGH);
    done_d  = (state_q == GAP) && (state_d == IDLE);
    sdata_d = 1'b0;
    case (state_d)
      LOW:     sdata_d = (state_q == LOW) ? serial_data : shift_d[0];
      HIGH:    sdata_d = serial_data;
      default: sdata_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bep_frame_encode.sv
// Directed bench for bep_frame_encode with CLK_DIV=2, GAP_CYCLES=4.
module tb_bep_frame_encode;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] address = '0;
  logic [7:0] parallel_in = '0;
  logic       write_enable = 1'b0;
  logic [7:0] parallel_out;
  logic       start = 1'b0;
  logic       busy, done, serial_data, serial_clock;

  int total = 0;
  int bad = 0;
  logic [7:0] mem [12];

  bep_frame_encode #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .address(address), .parallel_in(parallel_in),
    .write_enable(write_enable), .parallel_out(parallel_out), .start(start),
    .busy(busy), .done(done), .serial_data(serial_data), .serial_clock(serial_clock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] model_bits();
    logic [95:0] r;
    for (int i = 0; i < 12; i++) r[i*8 +: 8] = mem[i];
    return r;
  endfunction

  task automatic apply(input vec_t v);
    address = v.addr; parallel_in = v.data; write_enable = v.we;
    @(posedge clk); #1;
    write_enable = 1'b0;
    if (v.we && v.addr < 4'd12) mem[v.addr] = v.data;
    chk($sformatf("rd_addr%0d", v.addr), {88'd0, parallel_out}, {88'd0, v.exp});
  endtask

  // Entered at the first cycle after the start edge; returns at the done cycle,
  // or at the cycle where reset was raised (mode 2). mode 1 injects a write+start.
  task automatic capture(input int mode, input int inj_at, input logic [3:0] inj_addr,
                         input logic [7:0] inj_data, input logic hold,
                         output logic [95:0] bits, output int nedges, output int done_cyc,
                         output int busy_cnt, output int first_busy, output int unstable);
    logic prev_sclk, prev_sdata;
    bit did;
    bits = '0; nedges = 0; done_cyc = -1; busy_cnt = 0; unstable = 0; did = 0;
    first_busy = int'(busy);
    prev_sclk = 1'b0; prev_sdata = serial_data;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      if (serial_clock && !prev_sclk) begin
        if (nedges < 96) bits[nedges] = serial_data;
        nedges++;
      end
      if (serial_clock && prev_sclk && serial_data != prev_sdata) unstable++;
      if (busy) busy_cnt++;
      if (done) begin done_cyc = cyc; break; end
      prev_sclk = serial_clock; prev_sdata = serial_data;
      write_enable = 1'b0; start = hold;
      if (mode == 1 && !did && nedges == inj_at) begin
        address = inj_addr; parallel_in = inj_data; write_enable = 1'b1; start = 1'b1; did = 1;
      end
      if (mode == 2 && nedges == inj_at) begin reset = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] bits, exp;
    int ne, dc, bc, fb, us, cnt;
    for (int i = 0; i < 12; i++) mem[i] = 8'h00;

    for (int a = 0; a < 16; a++) tbl.push_back('{1'b0, 4'(a), 8'h00, 8'h00});
    tbl.push_back('{1'b1, 4'd0,  8'h78, 8'h78});
    tbl.push_back('{1'b1, 4'd1,  8'h56, 8'h56});
    tbl.push_back('{1'b1, 4'd2,  8'h34, 8'h34});
    tbl.push_back('{1'b1, 4'd3,  8'h12, 8'h12});
    tbl.push_back('{1'b1, 4'd13, 8'hAA, 8'h00});
    tbl.push_back('{1'b1, 4'd8,  8'h5A, 8'h5A});
    tbl.push_back('{1'b1, 4'd11, 8'hC3, 8'hC3});
    tbl.push_back('{1'b0, 4'd0,  8'h00, 8'h78});
    tbl.push_back('{1'b0, 4'd1,  8'h00, 8'h56});
    tbl.push_back('{1'b0, 4'd2,  8'h00, 8'h34});
    tbl.push_back('{1'b0, 4'd3,  8'h00, 8'h12});
    tbl.push_back('{1'b0, 4'd13, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 4'd12, 8'h00, 8'h00});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", {95'd0, busy}, 96'd0);
    chk("rst_done", {95'd0, done}, 96'd0);
    chk("rst_sclk", {95'd0, serial_clock}, 96'd0);
    chk("rst_sdata", {95'd0, serial_data}, 96'd0);

    foreach (tbl[i]) apply(tbl[i]);

    // Plain frame
    exp = model_bits();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    capture(0, 0, 4'd0, 8'h00, 1'b0, bits, ne, dc, bc, fb, us);
    chk("f1_first_busy", 96'(fb), 96'd1);
    chk("f1_first8", {88'd0, bits[7:0]}, {88'd0, 8'h78});
    chk("f1_edges", 96'(ne), 96'd96);
    chk("f1_done_cyc", 96'(dc), 96'd389);
    chk("f1_busy_len", 96'(bc), 96'd388);
    chk("f1_bits", bits, exp);
    chk("f1_stable", 96'(us), 96'd0);
    chk("f1_done_busy", {95'd0, busy}, 96'd0);
    @(posedge clk); #1;
    chk("f1_done_once", {95'd0, done}, 96'd0);

    // Write + start mid-frame
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    capture(1, 41, 4'd8, 8'hFF, 1'b0, bits, ne, dc, bc, fb, us);
    mem[8] = 8'hFF;
    chk("f2_byte8_old", {88'd0, bits[71:64]}, {88'd0, 8'h5A});
    chk("f2_done_cyc", 96'(dc), 96'd389);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (busy) cnt++; end
    chk("f2_start_dropped", 96'(cnt), 96'd0);
    exp = model_bits();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    capture(0, 0, 4'd0, 8'h00, 1'b0, bits, ne, dc, bc, fb, us);
    chk("f3_byte8_new", {88'd0, bits[71:64]}, {88'd0, 8'hFF});
    chk("f3_bits", bits, exp);

    // Reset during HIGH of bit 50
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    capture(2, 51, 4'd0, 8'h00, 1'b0, bits, ne, dc, bc, fb, us);
    chk("ab_edges", 96'(ne), 96'd51);
    chk("ab_sclk_before", {95'd0, serial_clock}, 96'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ab_busy", {95'd0, busy}, 96'd0);
    chk("ab_sclk", {95'd0, serial_clock}, 96'd0);
    chk("ab_sdata", {95'd0, serial_data}, 96'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin if (done || busy) cnt++; @(posedge clk); #1; end
    chk("ab_no_done", 96'(cnt), 96'd0);
    for (int i = 0; i < 12; i++) mem[i] = 8'h00;
    for (int a = 0; a < 12; a++) apply('{1'b0, 4'(a), 8'h00, 8'h00});

    // Start held high: back-to-back frames
    apply('{1'b1, 4'd0, 8'h01, 8'h01});
    exp = model_bits();
    start = 1'b1; @(posedge clk); #1;
    capture(1, 10, 4'd0, 8'h00, 1'b1, bits, ne, dc, bc, fb, us);
    mem[0] = 8'h00;
    chk("b1_bit0", {95'd0, bits[0]}, 96'd1);
    chk("b1_bits", bits, exp);
    chk("b1_done_cyc", 96'(dc), 96'd389);
    @(posedge clk); #1;
    chk("b2_busy_next", {95'd0, busy}, 96'd1);
    chk("b2_sdata0", {95'd0, serial_data}, 96'd0);
    exp = model_bits();
    capture(0, 0, 4'd0, 8'h00, 1'b1, bits, ne, dc, bc, fb, us);
    start = 1'b0;
    chk("b2_bits", bits, exp);
    chk("b2_done_cyc", 96'(dc), 96'd389);
    @(posedge clk); #1;
    chk("b2_idle_after", {95'd0, busy}, 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bep_frame_encode.md
Name: bep_frame_encode

Overview:
- Transmit-side counterpart of the BEP thermostat frame decoder.
- A host writes the 12 frame bytes through an addressed parallel port, using the same field map as the receive side, then pulses start.
- The block snapshots the bytes and serialises a 96-bit frame on serial_data/serial_clock, which the receive-side decoder consumes directly.
- Used for loopback self-test and for driving thermostat traffic toward the bus.

Parameters:
CLK_DIV, 4, clk cycles per serial_clock half-period (legal values >= 1)
GAP_CYCLES, 8, idle clk cycles after the last bit before done (legal values >= 1)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
address  input  4  byte select for write and readback
parallel_in  input  8  write data
write_enable  input  1  when high, writes parallel_in to register[address] at the clock edge
parallel_out  output  8  combinational readback of register[address]
start  input  1  request to transmit one frame
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse at end of frame
serial_data  output  1  frame bit stream
serial_clock  output  1  bit clock; receiver samples serial_data on the rising edge

Behaviour:
Register map:
- 0-3: thermostat_id[7:0] through [31:24].
- 4-5: room_temp low/high.
- 6-7: set_temp low/high.
- 8: state.
- 9-11: tail_1 to tail_3.
- 12-15: writes ignored; parallel_out reads 8'h00.
- Writes are accepted in every state. A write during a frame affects only the next frame.

Reset:
- All 12 registers, shift buffer and counters are cleared.
- busy=0, done=0, serial_data=0, serial_clock=0, state=IDLE.
- Reset mid-frame aborts the frame immediately. No done pulse is generated.

State machine (IDLE, LOW, HIGH, GAP):
- IDLE:
  - serial_clock=0, serial_data=0.
  - start=1 at edge T copies the registers into a 96-bit shift buffer and clears the bit counter (0..95). The state moves to LOW.
  - If write_enable is high in the same cycle as start, the snapshot takes the pre-write value.
- LOW:
  - busy=1, serial_clock=0, serial_data = current bit. Lasts CLK_DIV cycles, then HIGH.
  - First LOW cycle is T+1, carrying bit 0.
- HIGH:
  - serial_clock=1, serial_data unchanged. Lasts CLK_DIV cycles.
  - If the bit counter is below 95: increment it and go to LOW with the next bit.
  - If the bit counter is 95: go to GAP.
- GAP:
  - serial_clock=0, serial_data=0, busy=1. Lasts GAP_CYCLES cycles.
  - On exit, return to IDLE. busy=0 and done=1 in that same cycle, for exactly one cycle.

Bit order:
- Byte 0 first, byte 11 last. Each byte is sent LSB first.
- Bit n = register[n/8][n%8].

Timing:
- serial_data changes only on the first LOW cycle of each bit, so it is stable for CLK_DIV cycles before and throughout HIGH.
- Frame duration: busy is high for 192*CLK_DIV + GAP_CYCLES cycles.

Start handling:
- start while busy (LOW/HIGH/GAP) is ignored. It is not queued.
- start on the done cycle (state is IDLE) is accepted, giving back-to-back frames.

Outputs are registered, except parallel_out.

Test Plan:
1. Reset, then read addresses 0-15 -> all 8'h00; busy=0, serial_clock=0, serial_data=0.
2. Write 0x78,0x56,0x34,0x12 to addresses 0-3; write 0xAA to address 13 -> readback of addresses 0-3 matches; address 13 reads 0x00.
3. CLK_DIV=2, GAP_CYCLES=4, byte0=0x78, start pulse at T -> busy rises at T+1; the first 8 serial_clock rising edges sample 0,0,0,1,1,1,1,0; exactly 96 rising edges occur; done pulses once at T+389 with busy falling there.
4. Mid-frame (after bit 40) write 0xFF to address 8 and pulse start -> the current frame's bits 64-71 keep their old value; start is ignored; the next frame carries 0xFF in bits 64-71.
5. Assert reset while in HIGH of bit 50 -> next cycle busy=0, serial_clock=0, serial_data=0; no done pulse; all registers read 0x00.
6. Hold start high continuously -> back-to-back frames; each new frame's first LOW begins the cycle after its done pulse, and bit 0 reflects the current register contents.
